seg_disp_ctrl: RTL and testbench

// Multi-digit 7-segment display controller for the board I/O path. Accepts a

---
 rtl/seg_disp_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_seg_disp_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_disp_ctrl.sv
// ---------------------------------------------------------------------------
// seg_disp_ctrl
//
// Multi-digit 7-segment display controller. A binary value is accepted over a
// valid/ready handshake, converted to BCD with a sequential double-dabble (one
// shift per clock), and then shown on DIGITS common-anode digits. A single
// decoder is time-multiplexed across the digits. The display is double
// buffered: the previous value stays on screen while a new one converts.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   in_valid  in_data is valid
//   in_ready  controller idle, can accept a value (registered)
//   in_data   unsigned value to display (BIN_W bits)
//   blank_lz  1 = blank leading zeros, sampled at accept
//   busy      conversion in progress (== !in_ready)
//   ovf       last accepted value exceeded 10**DIGITS-1 (registered)
//   seg       segment drive, active-low, seg[6]=a .. seg[0]=g (registered)
//   an        digit select, one-hot active-low, bit 0 = rightmost (registered)
// ---------------------------------------------------------------------------
module seg_disp_ctrl #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int BIN_W    = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BIN_W-1:0]  in_data,
    input  logic              blank_lz,
    output logic              busy,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [31:0] MAXV = 32'(10 ** DIGITS - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    // Conversion side
    state_t             state_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               blank_pend_reg;
    logic               ovf_pend_reg;
    logic               in_ready_reg;

    // Display buffer (what the scan side reads)
    logic [BCD_W-1:0]   disp_reg;
    logic               blank_reg;
    logic               ovf_reg;

    // Scan side
    logic [DIV_W-1:0]   div_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [6:0]         seg_reg;
    logic [DIGITS-1:0]  an_reg;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic [DIGITS-1:0]  blank_mask;
    logic [3:0]         digit [DIGITS];
    logic [6:0]         seg_next;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift,
    // so that the shift carries correctly into the next decimal digit.
    // Leading-zero blanking: digit gi is dark when it and every digit above it
    // are zero. Digit 0 is never blanked so a value of 0 still shows "0".
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_reg[4*gi +: 4] + 4'd3
                                      : bcd_reg[4*gi +: 4];
            assign digit[gi] = disp_reg[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign blank_mask[gi] = 1'b0;
            end else begin : g_upper
                assign blank_mask[gi] = blank_reg &&
                                        (disp_reg[BCD_W-1:4*gi] == '0);
            end
        end
    endgenerate

    // Top BCD bit falls off the shift; it can only be set for values > MAXV,
    // whose BCD result is not used.
    assign bcd_shift = BCD_W'({bcd_adj, bin_reg[BIN_W-1]});

    assign in_ready = in_ready_reg;
    assign busy     = ~in_ready_reg;
    assign ovf      = ovf_reg;
    assign seg      = seg_reg;
    assign an       = an_reg;

    // Accept -> CONV (BIN_W shifts) -> LOAD (buffer update) -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bin_reg        <= '0;
            bcd_reg        <= '0;
            cnt_reg        <= '0;
            blank_pend_reg <= 1'b1;
            ovf_pend_reg   <= 1'b0;
            in_ready_reg   <= 1'b1;
            disp_reg       <= '0;
            blank_reg      <= 1'b1;
            ovf_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        bin_reg        <= in_data;
                        blank_pend_reg <= blank_lz;
                        ovf_pend_reg   <= (32'(in_data) > MAXV);
                        bcd_reg        <= '0;
                        cnt_reg        <= '0;
                        in_ready_reg   <= 1'b0;
                        state_reg      <= CONV;
                    end
                end
                CONV: begin
                    bcd_reg <= bcd_shift;
                    bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(BIN_W - 1)) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    disp_reg     <= bcd_reg;
                    blank_reg    <= blank_pend_reg;
                    ovf_reg      <= ovf_pend_reg;
                    in_ready_reg <= 1'b1;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        seg_next = decode(digit[idx_reg]);
        if (blank_mask[idx_reg]) begin
            seg_next = SEG_BLANK;
        end
        if (ovf_reg) begin
            seg_next = SEG_DASH;
        end
    end

    // Free-running scan. seg and an are both registered from the same index,
    // so they always change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= '0;
            idx_reg <= '0;
            seg_reg <= SEG_BLANK;
            an_reg  <= '1;
        end else begin
            seg_reg <= seg_next;
            an_reg  <= ~(DIGITS'(1) << idx_reg);
            if (div_reg == DIV_W'(SCAN_DIV - 1)) begin
                div_reg <= '0;
                idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0
                                                           : idx_reg + IDX_W'(1);
            end else begin
                div_reg <= div_reg + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg_disp_ctrl.sv
module tb_seg_disp_ctrl;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic        blank_lz = 1'b0;
    logic [13:0] in_data  = '0;
    logic        in_ready;
    logic        busy;
    logic        ovf;
    logic [6:0]  seg;
    logic [3:0]  an;

    seg_disp_ctrl #(
        .DIGITS   (4),
        .SCAN_DIV (4),
        .BIN_W    (14)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .blank_lz (blank_lz),
        .busy     (busy),
        .ovf      (ovf),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the value currently expected on the display.
    int   exp_val   = 0;
    bit   exp_blank = 1'b1;
    bit   exp_ovf   = 1'b0;

    // Scan tracking: dwell length and digit order.
    logic [3:0] last_an  = 4'hF;
    int         last_idx = 0;
    int         run_len  = 0;
    int         nchg     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // What digit i should show, straight from decimal arithmetic.
    function automatic logic [6:0] ref_seg(input int i);
        int p;
        int d;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (exp_ovf) return 7'b1111110;
        if (exp_blank && i > 0 && exp_val < p) return 7'b1111111;
        d = (exp_val / p) % 10;
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    task automatic scan_chk();
        int i;
        i = -1;
        for (int k = 0; k < 4; k++) begin
            if (an === ~(4'b0001 << k)) i = k;
        end
        chk("an_onehot", 32'(i >= 0), 32'd1);
        if (i >= 0) begin
            chk($sformatf("seg_d%0d", i), 32'(seg), 32'(ref_seg(i)));
            if (an === last_an) begin
                run_len++;
            end else begin
                if (nchg >= 1) begin
                    chk("dwell", run_len, 4);
                    chk("order", i, (last_idx + 1) % 4);
                end
                nchg++;
                last_an  = an;
                last_idx = i;
                run_len  = 1;
            end
        end
    endtask

    task automatic tick_raw();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        scan_chk();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic reset_tracker();
        last_an  = 4'hF;
        last_idx = 0;
        run_len  = 0;
        nchg     = 0;
    endtask

    task automatic send(input int v, input bit b);
        int k;
        in_data  = 14'(v);
        blank_lz = b;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        tick();                              // accept edge
        in_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        k = 0;
        while (!in_ready && k < 100) begin   // old value must stay on screen
            tick();
            k++;
        end
        chk("busy_cycles", k, 15);
        exp_val   = v;
        exp_blank = b;
        exp_ovf   = (v > 9999);
        chk("ovf", 32'(ovf), 32'(exp_ovf));
        $display("send value=%0d blank_lz=%0b busy_cycles=%0d ovf=%0b", v, b, k, ovf);
    endtask

    initial begin
        int k;
        int v;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick_raw();
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("first_an", 32'(an), 32'hE);
        chk("first_seg", 32'(seg), 32'b0000001);
        run(31);

        // Basic conversions and boundary values
        send(1234, 1'b1);  run(20);
        send(10000, 1'b1); run(20);
        chk("ovf_set", 32'(ovf), 32'd1);
        send(9999, 1'b1);  run(20);
        chk("ovf_clear", 32'(ovf), 32'd0);
        send(7, 1'b0);     run(20);
        send(0, 1'b1);     run(20);
        send(10, 1'b1);    run(20);
        send(1000, 1'b1);  run(20);
        send(16383, 1'b0); run(20);

        // Back-to-back: 42 held, then 7 presented right after acceptance
        in_data  = 14'd42;
        blank_lz = 1'b1;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        tick();                              // 42 accepted
        in_data = 14'd7;
        k = 0;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        exp_val = 42; exp_blank = 1'b1; exp_ovf = 1'b0;
        tick();                              // 7 accepted here
        k++;
        chk("b2b_gap", k, 16);
        chk("b2b_busy", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        $display("send value=42 then 7 back-to-back gap=%0d", k);
        k = 0;
        while (!in_ready && k < 100) begin   // display must hold 42
            tick();
            k++;
        end
        chk("b2b_busy_cycles", k, 15);
        exp_val = 7;
        run(20);

        // Reset in the middle of a conversion, with ovf set beforehand
        send(12345, 1'b0); run(8);
        in_data  = 14'd9999;
        blank_lz = 1'b0;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        repeat (2) tick_raw();
        exp_val = 0; exp_blank = 1'b1; exp_ovf = 1'b0;
        reset_tracker();
        rst_n = 1'b1;
        tick();
        chk("midrst_first_an", 32'(an), 32'hE);
        chk("midrst_first_seg", 32'(seg), 32'b0000001);
        run(30);
        chk("midrst_ready_after", 32'(in_ready), 32'd1);
        $display("reset during conversion of 9999, display back to 0");

        // Randomised values, some above range
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(10000, 16383));
            else v = int'($urandom_range(0, 9999));
            send(v, 1'($urandom_range(0, 1)));
            run(int'($urandom_range(16, 24)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
